// File: rtl/mux_rr_arbiter_if.sv
// Bundle of request, data, select and grant signals shared between requester
// logic (master) and the round-robin arbiter (slave).
// Optional feature macro: MUX_ARB_LOCK_EN adds the 'lock' signal.
interface mux_rr_arbiter_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  i;
    logic [SW-1:0] s;
    logic [N-1:0]  gnt;
    logic          busy;
    logic          sw_pulse;
    logic          o;
`ifdef MUX_ARB_LOCK_EN
    logic          lock;

    modport master (output req, i, lock, input s, gnt, busy, sw_pulse, o);
    modport slave  (input req, i, lock, output s, gnt, busy, sw_pulse, o);
`else
    modport master (output req, i, input s, gnt, busy, sw_pulse, o);
    modport slave  (input req, i, output s, gnt, busy, sw_pulse, o);
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared N:1 mux.
// Picks a winner circularly from a priority pointer, registers the select
// index and one-hot grant, limits each tenure to MAX_HOLD cycles and gates
// the shared output so it reads 0 while nobody owns the mux.
// Optional feature macro: MUX_ARB_LOCK_EN (lock input suppresses the
// MAX_HOLD timeout while the owner keeps requesting).
module mux_rr_arbiter #(
    parameter int N        = 8,
    parameter int SW       = $clog2(N),
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_rr_arbiter_if.slave      bus
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [7:0]   HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t        r_state, w_state_next;
    logic [SW-1:0] r_ptr, w_ptr_next;
    logic [SW-1:0] r_s, w_s_next;
    logic [N-1:0]  r_gnt, w_gnt_next;
    logic          r_busy, w_busy_next;
    logic          r_sw_pulse, w_sw_pulse_next;
    logic [7:0]    r_hold_cnt, w_hold_next;

    logic [SW-1:0] w_search_ptr;
    logic [SW-1:0] w_rot_idx [N];
    logic [N-1:0]  w_rot_req;
    logic          w_found;
    logic [SW-1:0] w_winner;
    logic          w_req_cur;
    logic          w_lock_hold;
    logic          w_release;

    // The search for a new owner starts at the stored pointer when idle and
    // right after the current owner when a tenure ends, so handover needs no
    // extra cycle.
    assign w_search_ptr = (r_state == GRANT) ? (r_s + SW'(1)) : r_ptr;

    // Rotate the request vector so position 0 is the highest priority slot;
    // index arithmetic wraps naturally because N is a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot_idx[gi] = w_search_ptr + SW'(gi);
            assign w_rot_req[gi] = bus.req[w_rot_idx[gi]];
        end
    endgenerate

    // Priority encode the rotated requests: lowest rotated position wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot_req[k]) begin
                w_found  = 1'b1;
                w_winner = w_rot_idx[k];
            end
        end
    end

    assign w_req_cur = bus.req[r_s];

`ifdef MUX_ARB_LOCK_EN
    assign w_lock_hold = bus.lock & w_req_cur;
`else
    assign w_lock_hold = 1'b0;
`endif

    // A tenure ends when the owner lets go or has used up its hold budget
    // (unless lock is holding it).
    assign w_release = !w_req_cur || ((r_hold_cnt >= HOLD_MAX) && !w_lock_hold);

    // Next-state and registered-output logic for the IDLE/GRANT sequencer.
    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_s_next        = r_s;
        w_gnt_next      = r_gnt;
        w_busy_next     = r_busy;
        w_sw_pulse_next = 1'b0;
        w_hold_next     = r_hold_cnt;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next    = GRANT;
                    w_s_next        = w_winner;
                    w_gnt_next      = ONE_HOT0 << w_winner;
                    w_busy_next     = 1'b1;
                    w_sw_pulse_next = 1'b1;
                    w_hold_next     = 8'd1;
                end
            end
            GRANT: begin
                if (!w_release) begin
                    // Saturate so a locked tenure never wraps the counter.
                    if (r_hold_cnt < HOLD_MAX) begin
                        w_hold_next = r_hold_cnt + 8'd1;
                    end
                end else begin
                    w_ptr_next = r_s + SW'(1);
                    if (w_found) begin
                        w_s_next        = w_winner;
                        w_gnt_next      = ONE_HOT0 << w_winner;
                        w_busy_next     = 1'b1;
                        w_sw_pulse_next = 1'b1;
                        w_hold_next     = 8'd1;
                    end else begin
                        // Select keeps its last value; only grant/busy drop.
                        w_state_next = IDLE;
                        w_gnt_next   = '0;
                        w_busy_next  = 1'b0;
                        w_hold_next  = 8'd0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
                w_busy_next  = 1'b0;
                w_hold_next  = 8'd0;
            end
        endcase
    end

    // State and output registers; reset clears any tenure immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_s        <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_sw_pulse <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_s        <= w_s_next;
            r_gnt      <= w_gnt_next;
            r_busy     <= w_busy_next;
            r_sw_pulse <= w_sw_pulse_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    assign bus.s        = r_s;
    assign bus.gnt      = r_gnt;
    assign bus.busy     = r_busy;
    assign bus.sw_pulse = r_sw_pulse;
    // Shared mux output is gated so a free mux reads as 0.
    assign bus.o        = r_busy ? bus.i[r_s] : 1'b0;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer that shares one N:1 multiplexer output among N requesters.
- Owns the mux select lines: it picks a winner, drives the select as a registered binary index, and gates the shared output.
- Limits each tenure with a hold timeout so no requester starves.
- Sits between requester logic and the existing Mux4x1/Mux8x1/Mux16x1 family.

Parameters:
- N, 8, number of requesters / mux inputs; power of two, 2..16.
- SW, $clog2(N), select width (derived; do not override).
- MAX_HOLD, 4, maximum consecutive cycles one grant may last; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-requester request, level-sensitive
- i  in  N  mux data inputs; i[k] belongs to requester k
- s  out  SW  registered select index of the current owner (drives the mux)
- gnt  out  N  registered one-hot grant, or all zero
- busy  out  1  high while any grant is active
- sw_pulse  out  1  one-cycle pulse on the first cycle of every new grant (includes re-grant)
- o  out  1  i[s] when busy=1, else 0 (combinational)

Behaviour:
- Reset (async assert, sync-safe release) forces:
  - s=0, gnt=0, busy=0, sw_pulse=0, o=0
  - internal priority pointer ptr=0, hold_cnt=0, state=IDLE
- Reset asserted mid-grant clears everything immediately; no partial tenure resumes.
- States are IDLE and GRANT.
- Winner search: first k with req[k]=1 scanning ptr, ptr+1, ... wrapping mod N.
- IDLE:
  - If any req=1, at the next edge: gnt=onehot(winner), s=winner, busy=1, sw_pulse=1, hold_cnt=1, goto GRANT.
  - Latency req→gnt is exactly 1 cycle.
  - If no req, all outputs hold reset values.
- GRANT, per cycle:
  - Continue while req[s]=1 and hold_cnt<MAX_HOLD: hold_cnt+=1, sw_pulse=0.
  - Release occurs when req[s]=0 (voluntary) or hold_cnt==MAX_HOLD with req[s]=1 (forced).
  - On release, ptr := (s+1) mod N, and the winner search starts from the new ptr in the same cycle.
  - Winner found: the new grant is loaded at that edge (zero-bubble handover), with sw_pulse=1 and hold_cnt=1.
  - No winner: return to IDLE, gnt=0, busy=0; s keeps its last value.
- Forced release with the same requester as sole requester: it is re-granted immediately, sw_pulse=1, hold_cnt restarts at 1.
- Requests arriving mid-tenure are not considered until release; gnt never changes mid-tenure.
- Simultaneous requests in IDLE: the lowest index at or after ptr wins, circularly.
- MAX_HOLD=1: every grant lasts exactly one cycle; pure per-cycle round robin.
- hold_cnt is 8 bits and saturates at MAX_HOLD; it never wraps.
- Invariants:
  - gnt is always one-hot or zero.
  - busy == |gnt.
  - When busy=1, gnt[s]=1.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit), sampled each cycle in GRANT.
  - While lock=1 and req[s]=1, the MAX_HOLD forced release is suppressed; hold_cnt saturates at MAX_HOLD.
  - Dropping lock with hold_cnt==MAX_HOLD forces release on that cycle's edge.
  - lock has no effect in IDLE.
- Not defined: no lock port; the timeout always applies.

Test Plan:
- Reset, then req=8'h00 for 5 cycles → gnt=0, busy=0, s=0, o=0 throughout; assert rst_n=0 mid-grant → all outputs 0 within the same cycle.
- req=8'h01 held 10 cycles, MAX_HOLD=4 → grant to 0 at cycle 1; forced re-grant every 4 cycles; sw_pulse at cycles 1, 5, 9; s=0; o follows i[0].
- req=8'h81 held → grants alternate 0,7,0,7…, each 4 cycles, no idle cycle between; s toggles 0/7.
- req=8'h24 from IDLE with ptr=3 → requester 5 first (s=5), then 2; requester 5 drops req after 2 cycles → handover to 2 on the next edge, sw_pulse=1.
- i=8'b1010_0101, requesters 0..7 each request for 1 cycle in turn → o sequence equals i[s] while busy, 0 when busy=0; gnt one-hot checked every cycle.
- MUX_ARB_LOCK_EN defined, req=8'h03, lock=1 for 8 cycles → requester 0 keeps its grant 8 cycles; lock=0 → release that edge, grant to 1.
